// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state type, sizing helpers and round-robin pick for the 2-master arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} arb_state_t;

  localparam int DEF_OUTST_W = 4;

  function automatic int outst_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int OUTST_MAX = outst_max(DEF_OUTST_W);

  // On a tie the master that did not own the bus last time wins.
  function automatic arb_state_t next_grant(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return last ? GRANT0 : GRANT1;
    if (req0)         return GRANT0;
    if (req1)         return GRANT1;
    return IDLE;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - Wishbone B4 pipelined bus bundle with master/slave views
interface wishbone_if;
  logic [31:0] addr;
  logic [31:0] data_m;
  logic [31:0] data_s;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        stall;
  logic        err;

  modport master (output addr, data_m, we, cyc, stb, input data_s, ack, stall, err);
  modport slave  (input addr, data_m, we, cyc, stb, output data_s, ack, stall, err);
endinterface

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - outstanding-transfer counter and hung-slave timer for the owning master
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int OUTST_W = DEF_OUTST_W,
  parameter int TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic accept_i,
  input  logic resp_i,
  input  logic clear_i,
  output logic outstanding_full_o,
  output logic timeout_o
);

  localparam logic [OUTST_W-1:0] MAX = OUTST_W'(outst_max(OUTST_W));
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [OUTST_W-1:0] outst_q, outst_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               busy;

  assign busy = active_i && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    timer_d = '0;
    if (clear_i) begin
      outst_d = '0;
    end else if (active_i) begin
      if (accept_i && !resp_i && outst_q != MAX)
        outst_d = outst_q + 1'b1;
      else if (!accept_i && resp_i && outst_q != '0)
        outst_d = outst_q - 1'b1;
      if (busy && !resp_i)
        timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_q <= '0;
      timer_q <= '0;
    end else begin
      outst_q <= outst_d;
      timer_q <= timer_d;
    end
  end

  assign outstanding_full_o = (outst_q == MAX);
  assign timeout_o          = busy && !resp_i && (timer_q == TLAST);

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone arbiter with cyc lock and watchdog abort
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int OUTST_W = DEF_OUTST_W,
  parameter int TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wishbone_if.slave   m0,
  wishbone_if.slave   m1,
  wishbone_if.master  s
);

  arb_state_t  state_q;
  logic        last_q;

  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_addr, own_data;
  logic        granted, release_w, s_stb_w, accept, resp;
  logic        outst_full, timeout;

  always_comb begin
    if (state_q == GRANT1) begin
      own_cyc  = m1.cyc;
      own_stb  = m1.stb;
      own_we   = m1.we;
      own_addr = m1.addr;
      own_data = m1.data_m;
    end else begin
      own_cyc  = m0.cyc;
      own_stb  = m0.stb;
      own_we   = m0.we;
      own_addr = m0.addr;
      own_data = m0.data_m;
    end
  end

  assign granted   = (state_q == GRANT0) || (state_q == GRANT1);
  assign release_w = granted && !own_cyc;
  assign s_stb_w   = granted && own_cyc && own_stb && !outst_full;
  assign accept    = s_stb_w && !s.stall;
  assign resp      = s.ack || s.err;

  wb_arb_watchdog #(
    .OUTST_W (OUTST_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .active_i           (granted),
    .accept_i           (accept),
    .resp_i             (resp),
    .clear_i            (release_w || (state_q == ABORT)),
    .outstanding_full_o (outst_full),
    .timeout_o          (timeout)
  );

  // Release hands the bus straight to a waiting master; abort always passes through IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: state_q <= next_grant(m0.cyc, m1.cyc, last_q);
        GRANT0: begin
          if (!m0.cyc) begin
            last_q  <= 1'b0;
            state_q <= m1.cyc ? GRANT1 : IDLE;
          end else if (timeout) begin
            last_q  <= 1'b0;
            state_q <= ABORT;
          end
        end
        GRANT1: begin
          if (!m1.cyc) begin
            last_q  <= 1'b1;
            state_q <= m0.cyc ? GRANT0 : IDLE;
          end else if (timeout) begin
            last_q  <= 1'b1;
            state_q <= ABORT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s.cyc     = granted && own_cyc;
    s.stb     = s_stb_w;
    s.we      = own_we;
    s.addr    = own_addr;
    s.data_m  = own_data;
    m0.data_s = s.data_s;
    m1.data_s = s.data_s;
    m0.stall  = 1'b1;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m1.stall  = 1'b1;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    case (state_q)
      GRANT0: begin
        m0.stall = s.stall || outst_full;
        m0.ack   = s.ack;
        m0.err   = s.err;
      end
      GRANT1: begin
        m1.stall = s.stall || outst_full;
        m1.ack   = s.ack;
        m1.err   = s.err;
      end
      ABORT: begin
        if (last_q) m1.err = 1'b1;
        else        m0.err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
